bomb_pool_ctrl: RTL and testbench
=================================

// Module: bomb_pool_ctrl
// PURPOSE
// Parametrised bomb manager for the player: owns NUM_BOMBS bomb slots, each with its own fuse/blast timer.
// Handles grid-snapped drops, duplicate-tile rejection, chain detonation, and capacity/radius power-ups.
// Produces registered bomb/blast draw requests for the video mux and blast/explosion events for game logic.
// Sits between the keyboard/player blocks and the object-priority mux. Contains no bitmaps; RGB is selected downstream by draw_slot.
// PARAMETERS
// NUM_BOMBS     3  physical slots (1..8); upper bound on capacity
// START_BOMBS   2  capacity after reset/clear_all (1..NUM_BOMBS)
// FUSE_SEC      3  OneSecPulse ticks from drop to detonation (>=1)
// BLAST_SEC     1  OneSecPulse ticks a blast stays active (>=1)
// TILE_SHIFT    5  log2 tile size in pixels; tile coord width TW = 11-TILE_SHIFT
// START_RADIUS  1  blast radius (tiles) after reset; MAX_RADIUS 4 = radius ceiling
// PORTS
// clk              in   1   system clock
// resetN           in   1   asynchronous active-low reset
// OneSecPulse      in   1   1-cycle tick, once per second
// clear_all        in   1   sync pulse: abort all bombs (level restart)
// drop_bomb_key    in   1   level from keypad; rising edge requests a drop
// capacity_up      in   1   1-cycle pulse: +1 capacity
// radius_up        in   1   1-cycle pulse: +1 radius
// player_topLeftX  in   11  player position, pixels
// player_topLeftY  in   11
// pixelX, pixelY   in   11  current VGA pixel
// bomb_DR          out  1   pixel lies on a fused bomb tile (registered)
// blast_DR         out  1   pixel lies in an active blast cross (registered)
// draw_slot        out  3   slot index for bomb_DR/blast_DR; lowest index wins
// blast            out  1   1-cycle pulse when >=1 slot enters BLAST
// explosion        out  1   level: any slot in BLAST
// bombs_left       out  4   slots available to drop (0..capacity)
// radius           out  3   current radius register
// BEHAVIOUR
// - Reset (async) and clear_all (sync): all slots IDLE; bombs_left=capacity_reg; outputs 0.
//   Reset additionally forces capacity=START_BOMBS and radius=START_RADIUS. clear_all keeps capacity/radius and overrides all same-cycle events.
// - Per-slot state: IDLE -> FUSE -> BLAST -> IDLE. Per-slot regs: tileX, tileY [TW], cnt [4], rad [3].
// - Drop: rising edge of drop_bomb_key (1-cycle registered history). Accepted when all of:
//   - bombs_left>0
//   - a slot with index < capacity is IDLE
//   - no FUSE/BLAST slot holds the same tile
//   Rejected edges are discarded, not queued.
// - Accept: lowest IDLE slot; tileX = (player_topLeftX + 2^(TILE_SHIFT-1)) >> TILE_SHIFT, tileY likewise.
//   The slot also takes cnt=FUSE_SEC and rad=radius; it is in FUSE the next cycle.
// - FUSE: on OneSecPulse cnt--. When cnt==1 and pulse: -> BLAST, cnt=BLAST_SEC.
// - Chain: a FUSE slot whose tile is in any BLAST slot's cross goes -> BLAST next cycle, regardless of cnt or pulse.
//   Cross = same row with |dx|<=rad, or same column with |dy|<=rad.
// - blast: high exactly one cycle in any cycle where >=1 slot enters BLAST. Simultaneous entries give one pulse.
// - BLAST: on OneSecPulse cnt--; cnt==1 and pulse -> IDLE. The slot's bomb is returned on that cycle.
// - bombs_left next = bombs_left - accept + returns + cap_inc. All same-cycle events sum; the result never exceeds capacity.
// - capacity_up: if capacity<NUM_BOMBS, capacity++ and bombs_left++. Else ignored. radius_up saturates at MAX_RADIUS.
// - Draw: pixel tile pt = pixel>>TILE_SHIFT; outputs registered, 1-cycle latency.
//   bomb_DR when some FUSE slot has tile==pt. Else blast_DR when pt is in some BLAST cross.
//   bomb_DR takes priority over blast_DR. draw_slot is 0 when neither is set.
// - Radius is latched per slot at drop; later radius_up does not affect placed bombs.
// - Edge coordinates: cross arithmetic is done in TW+1 signed bits; no wrap across the screen edge.
// TESTING
// - Reset: press drop; edge at tile (3,2), pulses x3 -> slot0 FUSE at next clk; blast pulse 1 cycle at 3rd pulse; bombs_left 2->1->2 after BLAST_SEC.
// - Held key / duplicate: hold drop 100 cycles -> exactly one drop. Re-press on same tile -> rejected, bombs_left unchanged.
// - Capacity: 2 drops -> bombs_left=0; 3rd press rejected. capacity_up -> bombs_left=1; 4x capacity_up -> capacity saturates at 3.
// - Chain: bomb A at (4,4) dropped, then bomb B at (6,4) 1 s later, radius=2.
//   A blasts -> B enters BLAST the next cycle, with a second blast pulse. Radius=1 repeat -> B waits for its own fuse.
// - Simultaneous: return and accepted drop in the same cycle -> bombs_left unchanged. clear_all mid-FUSE -> all IDLE, bombs_left=capacity, no blast.
// - Draw: pixel (130,70) with bomb at tile (4,2) -> bomb_DR=1, draw_slot=0 one cycle later. Blast rad 1 at (4,2): tile (6,2) -> blast_DR=0.

Source files
------------

// File: rtl/bomb_pool_ctrl_if.sv
// Player-side bus of the bomb manager: timing/control inputs, player and
// VGA pixel positions, and the registered draw/event outputs.
interface bomb_pool_ctrl_if;
    logic        OneSecPulse;
    logic        clear_all;
    logic        drop_bomb_key;
    logic        capacity_up;
    logic        radius_up;
    logic [10:0] player_topLeftX;
    logic [10:0] player_topLeftY;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        bomb_DR;
    logic        blast_DR;
    logic [2:0]  draw_slot;
    logic        blast;
    logic        explosion;
    logic [3:0]  bombs_left;
    logic [2:0]  radius;

    // Game logic / keyboard side: drives requests, consumes draw and events
    modport master (
        output OneSecPulse, clear_all, drop_bomb_key, capacity_up, radius_up,
        output player_topLeftX, player_topLeftY, pixelX, pixelY,
        input  bomb_DR, blast_DR, draw_slot, blast, explosion, bombs_left, radius
    );

    // Bomb manager side
    modport slave (
        input  OneSecPulse, clear_all, drop_bomb_key, capacity_up, radius_up,
        input  player_topLeftX, player_topLeftY, pixelX, pixelY,
        output bomb_DR, blast_DR, draw_slot, blast, explosion, bombs_left, radius
    );
endinterface

// File: rtl/bomb_pool_ctrl.sv
// bomb_pool_ctrl: pool of NUM_BOMBS bomb slots, each IDLE -> FUSE -> BLAST.
// Handles tile-snapped drops with duplicate rejection, chain detonation
// through blast crosses, capacity/radius power-ups, and produces registered
// draw requests plus blast/explosion events. clear_all acts as the
// synchronous soft clear: it empties every slot but keeps the power-ups.
module bomb_pool_ctrl #(
    parameter int NUM_BOMBS    = 3,
    parameter int START_BOMBS  = 2,
    parameter int FUSE_SEC     = 3,
    parameter int BLAST_SEC    = 1,
    parameter int TILE_SHIFT   = 5,
    parameter int START_RADIUS = 1,
    parameter int MAX_RADIUS   = 4
) (
    input  logic            clk,
    input  logic            resetN,
    bomb_pool_ctrl_if.slave bus
);
    localparam int          TW        = 11 - TILE_SHIFT;
    localparam int          TW1       = TW + 1;
    localparam logic [3:0]  FUSE_CNT  = 4'(FUSE_SEC);
    localparam logic [3:0]  BLAST_CNT = 4'(BLAST_SEC);
    localparam logic [3:0]  CAP_START = 4'(START_BOMBS);
    localparam logic [3:0]  CAP_MAX   = 4'(NUM_BOMBS);
    localparam logic [2:0]  RAD_START = 3'(START_RADIUS);
    localparam logic [2:0]  RAD_MAX   = 3'(MAX_RADIUS);
    localparam logic [11:0] HALF_TILE = 12'(1 << (TILE_SHIFT - 1));

    typedef enum logic [1:0] {
        SLOT_IDLE  = 2'd0,
        SLOT_FUSE  = 2'd1,
        SLOT_BLAST = 2'd2
    } slot_state_t;

    slot_state_t   state_r  [NUM_BOMBS];
    logic [TW-1:0] tile_x_r [NUM_BOMBS];
    logic [TW-1:0] tile_y_r [NUM_BOMBS];
    logic [3:0]    cnt_r    [NUM_BOMBS];
    logic [2:0]    rad_r    [NUM_BOMBS];

    logic       key_d_r;
    logic [3:0] capacity_r;
    logic [3:0] bombs_left_r;
    logic [2:0] radius_r;
    logic       bomb_dr_r;
    logic       blast_dr_r;
    logic [2:0] draw_slot_r;
    logic       blast_r;
    logic       explosion_r;

    // Drop decision signals
    logic                 rise_s;
    logic                 dup_s;
    logic                 free_any_s;
    logic                 accept_s;
    logic [TW-1:0]        drop_tx_s;
    logic [TW-1:0]        drop_ty_s;
    logic [NUM_BOMBS-1:0] free_vec_s;
    logic [2:0]           free_idx_s;

    // Slot event signals
    logic [NUM_BOMBS-1:0] take_s;
    logic [NUM_BOMBS-1:0] chain_s;
    logic [NUM_BOMBS-1:0] enter_s;
    logic [NUM_BOMBS-1:0] return_s;
    logic [NUM_BOMBS-1:0] blast_next_s;
    logic [3:0]           ret_count_s;
    logic                 cap_inc_s;
    logic                 rad_inc_s;
    logic [3:0]           cap_next_s;
    logic [4:0]           left_sum_s;
    logic [3:0]           left_next_s;

    // Draw signals
    logic [TW-1:0]        pix_tx_s;
    logic [TW-1:0]        pix_ty_s;
    logic [NUM_BOMBS-1:0] bomb_vec_s;
    logic [NUM_BOMBS-1:0] blast_vec_s;
    logic                 bomb_hit_s;
    logic                 blast_hit_s;
    logic [2:0]           bomb_slot_s;
    logic [2:0]           blast_slot_s;

    // True when tile (px,py) lies on the cross of radius r centred at (cx,cy).
    // Differences are signed and one bit wider, so crosses never wrap.
    function automatic logic in_cross(
        input logic [TW-1:0] cx,
        input logic [TW-1:0] cy,
        input logic [2:0]    r,
        input logic [TW-1:0] px,
        input logic [TW-1:0] py
    );
        logic signed [TW:0] dx;
        logic signed [TW:0] dy;
        logic [TW:0]        adx;
        logic [TW:0]        ady;
        dx  = $signed({1'b0, px}) - $signed({1'b0, cx});
        dy  = $signed({1'b0, py}) - $signed({1'b0, cy});
        adx = dx[TW] ? $unsigned(-dx) : $unsigned(dx);
        ady = dy[TW] ? $unsigned(-dy) : $unsigned(dy);
        return ((py == cy) && (adx <= TW1'(r))) || ((px == cx) && (ady <= TW1'(r)));
    endfunction

    // Decide whether this cycle's key edge places a bomb, and in which slot
    always_comb begin
        rise_s     = bus.drop_bomb_key & ~key_d_r;
        drop_tx_s  = TW'(({1'b0, bus.player_topLeftX} + HALF_TILE) >> TILE_SHIFT);
        drop_ty_s  = TW'(({1'b0, bus.player_topLeftY} + HALF_TILE) >> TILE_SHIFT);
        dup_s      = 1'b0;
        free_vec_s = {NUM_BOMBS{1'b0}};
        free_idx_s = 3'd0;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            dup_s = dup_s | ((state_r[i] != SLOT_IDLE) &&
                             (tile_x_r[i] == drop_tx_s) && (tile_y_r[i] == drop_ty_s));
            free_vec_s[i] = (state_r[i] == SLOT_IDLE) && (4'(i) < capacity_r);
        end
        for (int i = NUM_BOMBS - 1; i >= 0; i--) begin
            free_idx_s = free_vec_s[i] ? 3'(i) : free_idx_s;
        end
        free_any_s = |free_vec_s;
        accept_s   = rise_s && (bombs_left_r != 4'd0) && free_any_s && !dup_s;
    end

    // Per-slot transitions (fuse expiry, chain hits, returns) and pool counters
    always_comb begin
        take_s       = {NUM_BOMBS{1'b0}};
        chain_s      = {NUM_BOMBS{1'b0}};
        enter_s      = {NUM_BOMBS{1'b0}};
        return_s     = {NUM_BOMBS{1'b0}};
        blast_next_s = {NUM_BOMBS{1'b0}};
        ret_count_s  = 4'd0;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            for (int j = 0; j < NUM_BOMBS; j++) begin
                chain_s[i] = chain_s[i] |
                    ((state_r[j] == SLOT_BLAST) &&
                     in_cross(tile_x_r[j], tile_y_r[j], rad_r[j], tile_x_r[i], tile_y_r[i]));
            end
            chain_s[i]      = chain_s[i] & (state_r[i] == SLOT_FUSE);
            take_s[i]       = accept_s && (free_idx_s == 3'(i));
            enter_s[i]      = (state_r[i] == SLOT_FUSE) &&
                              (chain_s[i] || (bus.OneSecPulse && (cnt_r[i] == 4'd1)));
            return_s[i]     = (state_r[i] == SLOT_BLAST) && bus.OneSecPulse && (cnt_r[i] == 4'd1);
            blast_next_s[i] = enter_s[i] || ((state_r[i] == SLOT_BLAST) && !return_s[i]);
            ret_count_s     = ret_count_s + {3'b000, return_s[i]};
        end
        cap_inc_s   = bus.capacity_up && (capacity_r < CAP_MAX);
        rad_inc_s   = bus.radius_up && (radius_r < RAD_MAX);
        cap_next_s  = capacity_r + {3'b000, cap_inc_s};
        left_sum_s  = {1'b0, bombs_left_r} + {1'b0, ret_count_s} +
                      {4'b0000, cap_inc_s} - {4'b0000, accept_s};
        left_next_s = (left_sum_s > {1'b0, cap_next_s}) ? cap_next_s : left_sum_s[3:0];
    end

    // Find the lowest fused slot on the pixel's tile and the lowest blast cross covering it
    always_comb begin
        pix_tx_s     = TW'(bus.pixelX >> TILE_SHIFT);
        pix_ty_s     = TW'(bus.pixelY >> TILE_SHIFT);
        bomb_vec_s   = {NUM_BOMBS{1'b0}};
        blast_vec_s  = {NUM_BOMBS{1'b0}};
        bomb_slot_s  = 3'd0;
        blast_slot_s = 3'd0;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            bomb_vec_s[i]  = (state_r[i] == SLOT_FUSE) &&
                             (tile_x_r[i] == pix_tx_s) && (tile_y_r[i] == pix_ty_s);
            blast_vec_s[i] = (state_r[i] == SLOT_BLAST) &&
                             in_cross(tile_x_r[i], tile_y_r[i], rad_r[i], pix_tx_s, pix_ty_s);
        end
        for (int i = NUM_BOMBS - 1; i >= 0; i--) begin
            bomb_slot_s  = bomb_vec_s[i]  ? 3'(i) : bomb_slot_s;
            blast_slot_s = blast_vec_s[i] ? 3'(i) : blast_slot_s;
        end
        bomb_hit_s  = |bomb_vec_s;
        blast_hit_s = |blast_vec_s;
    end

    // Slot lifecycle, pool counters and registered draw/event outputs
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_BOMBS; i++) begin
                state_r[i]  <= SLOT_IDLE;
                tile_x_r[i] <= {TW{1'b0}};
                tile_y_r[i] <= {TW{1'b0}};
                cnt_r[i]    <= 4'd0;
                rad_r[i]    <= 3'd0;
            end
            key_d_r      <= 1'b0;
            capacity_r   <= CAP_START;
            radius_r     <= RAD_START;
            bombs_left_r <= CAP_START;
            bomb_dr_r    <= 1'b0;
            blast_dr_r   <= 1'b0;
            draw_slot_r  <= 3'd0;
            blast_r      <= 1'b0;
            explosion_r  <= 1'b0;
        end else if (bus.clear_all) begin
            for (int i = 0; i < NUM_BOMBS; i++) begin
                state_r[i] <= SLOT_IDLE;
                cnt_r[i]   <= 4'd0;
            end
            key_d_r      <= bus.drop_bomb_key;
            bombs_left_r <= capacity_r;
            bomb_dr_r    <= 1'b0;
            blast_dr_r   <= 1'b0;
            draw_slot_r  <= 3'd0;
            blast_r      <= 1'b0;
            explosion_r  <= 1'b0;
        end else begin
            key_d_r      <= bus.drop_bomb_key;
            capacity_r   <= cap_next_s;
            radius_r     <= radius_r + {2'b00, rad_inc_s};
            bombs_left_r <= left_next_s;
            for (int i = 0; i < NUM_BOMBS; i++) begin
                case (state_r[i])
                    SLOT_IDLE: begin
                        if (take_s[i]) begin
                            state_r[i]  <= SLOT_FUSE;
                            tile_x_r[i] <= drop_tx_s;
                            tile_y_r[i] <= drop_ty_s;
                            cnt_r[i]    <= FUSE_CNT;
                            rad_r[i]    <= radius_r;
                        end
                    end
                    SLOT_FUSE: begin
                        if (enter_s[i]) begin
                            state_r[i] <= SLOT_BLAST;
                            cnt_r[i]   <= BLAST_CNT;
                        end else if (bus.OneSecPulse) begin
                            cnt_r[i] <= cnt_r[i] - 4'd1;
                        end
                    end
                    SLOT_BLAST: begin
                        if (return_s[i]) begin
                            state_r[i] <= SLOT_IDLE;
                            cnt_r[i]   <= 4'd0;
                        end else if (bus.OneSecPulse) begin
                            cnt_r[i] <= cnt_r[i] - 4'd1;
                        end
                    end
                    default: begin
                        state_r[i] <= SLOT_IDLE;
                        cnt_r[i]   <= 4'd0;
                    end
                endcase
            end
            bomb_dr_r   <= bomb_hit_s;
            blast_dr_r  <= !bomb_hit_s && blast_hit_s;
            draw_slot_r <= bomb_hit_s ? bomb_slot_s : (blast_hit_s ? blast_slot_s : 3'd0);
            blast_r     <= |enter_s;
            explosion_r <= |blast_next_s;
        end
    end

    assign bus.bomb_DR    = bomb_dr_r;
    assign bus.blast_DR   = blast_dr_r;
    assign bus.draw_slot  = draw_slot_r;
    assign bus.blast      = blast_r;
    assign bus.explosion  = explosion_r;
    assign bus.bombs_left = bombs_left_r;
    assign bus.radius     = radius_r;

endmodule

// File: tb/tb_bomb_pool_ctrl.sv
// Testbench for bomb_pool_ctrl: directed scenarios followed by random
// stimulus, every cycle checked against a seconds-remaining slot model.
module tb_bomb_pool_ctrl;
    localparam int NB = 3;
    localparam int SB = 2;
    localparam int FS = 3;
    localparam int BS = 1;
    localparam int TS = 5;
    localparam int SR = 1;
    localparam int MR = 4;
    localparam int TW = 11 - TS;

    logic clk = 1'b0;
    logic resetN;
    bomb_pool_ctrl_if bus();

    bomb_pool_ctrl #(
        .NUM_BOMBS(NB), .START_BOMBS(SB), .FUSE_SEC(FS), .BLAST_SEC(BS),
        .TILE_SHIFT(TS), .START_RADIUS(SR), .MAX_RADIUS(MR)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model: seconds of fuse / blast left per slot (0 = not in that phase)
    int m_fuse [NB];
    int m_blast[NB];
    int m_tx   [NB];
    int m_ty   [NB];
    int m_rad  [NB];
    int m_cap, m_radius, m_left, m_key;
    int e_bomb, e_blastdr, e_slot, e_blast, e_expl;

    task automatic check_val(input string tag, input int got, input int exp);
        n_compared++;
        if (got != exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic bit m_cross(input int j, input int px, input int py);
        return (m_blast[j] > 0) &&
               (((py == m_ty[j]) && (iabs(px - m_tx[j]) <= m_rad[j])) ||
                ((px == m_tx[j]) && (iabs(py - m_ty[j]) <= m_rad[j])));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            m_fuse[i] = 0; m_blast[i] = 0; m_tx[i] = 0; m_ty[i] = 0; m_rad[i] = 0;
        end
        m_cap = SB; m_radius = SR; m_left = SB; m_key = 0;
        e_bomb = 0; e_blastdr = 0; e_slot = 0; e_blast = 0; e_expl = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_step();
        int  n_fuse[NB];
        int  n_blast[NB];
        int  ptx, pty, tx, ty, free_i, returns;
        bit  rise, dup, acc, entered, chain, pulse;
        pulse = bus.OneSecPulse;
        ptx = int'(bus.pixelX) >> TS;
        pty = int'(bus.pixelY) >> TS;
        e_bomb = 0; e_blastdr = 0; e_slot = 0;
        for (int i = NB - 1; i >= 0; i--)
            if (m_fuse[i] > 0 && m_tx[i] == ptx && m_ty[i] == pty) begin e_bomb = 1; e_slot = i; end
        if (e_bomb == 0)
            for (int i = NB - 1; i >= 0; i--)
                if (m_cross(i, ptx, pty)) begin e_blastdr = 1; e_slot = i; end
        if (bus.clear_all) begin
            for (int i = 0; i < NB; i++) begin m_fuse[i] = 0; m_blast[i] = 0; end
            m_left = m_cap; m_key = int'(bus.drop_bomb_key);
            e_bomb = 0; e_blastdr = 0; e_slot = 0; e_blast = 0; e_expl = 0;
            return;
        end
        rise  = bus.drop_bomb_key && (m_key == 0);
        m_key = int'(bus.drop_bomb_key);
        tx = ((int'(bus.player_topLeftX) + (1 << (TS - 1))) >> TS) % (1 << TW);
        ty = ((int'(bus.player_topLeftY) + (1 << (TS - 1))) >> TS) % (1 << TW);
        dup = 0;
        for (int i = 0; i < NB; i++)
            if ((m_fuse[i] > 0 || m_blast[i] > 0) && m_tx[i] == tx && m_ty[i] == ty) dup = 1;
        free_i = -1;
        for (int i = NB - 1; i >= 0; i--)
            if (i < m_cap && m_fuse[i] == 0 && m_blast[i] == 0) free_i = i;
        acc = rise && (m_left > 0) && (free_i >= 0) && !dup;
        entered = 0; returns = 0;
        for (int i = 0; i < NB; i++) begin
            n_fuse[i] = m_fuse[i]; n_blast[i] = m_blast[i];
            if (m_fuse[i] > 0) begin
                chain = 0;
                for (int j = 0; j < NB; j++) if (m_cross(j, m_tx[i], m_ty[i])) chain = 1;
                if (chain || (pulse && m_fuse[i] == 1)) begin
                    n_fuse[i] = 0; n_blast[i] = BS; entered = 1;
                end else if (pulse) n_fuse[i] = m_fuse[i] - 1;
            end else if (m_blast[i] > 0 && pulse) begin
                n_blast[i] = m_blast[i] - 1;
                if (n_blast[i] == 0) returns++;
            end
        end
        if (acc) begin
            n_fuse[free_i] = FS; m_tx[free_i] = tx; m_ty[free_i] = ty; m_rad[free_i] = m_radius;
        end
        m_left = m_left - int'(acc) + returns;
        if (bus.capacity_up && m_cap < NB) begin m_cap++; m_left++; end
        if (m_left > m_cap) m_left = m_cap;
        if (bus.radius_up && m_radius < MR) m_radius++;
        e_expl = 0;
        for (int i = 0; i < NB; i++) begin
            m_fuse[i] = n_fuse[i]; m_blast[i] = n_blast[i];
            if (n_blast[i] > 0) e_expl = 1;
        end
        e_blast = int'(entered);
    endtask

    // One clock: predict, clock the DUT, compare all outputs away from the edge
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_val("bombs_left", int'(bus.bombs_left), m_left);
        check_val("radius",     int'(bus.radius),     m_radius);
        check_val("explosion",  int'(bus.explosion),  e_expl);
        check_val("blast",      int'(bus.blast),      e_blast);
        check_val("bomb_DR",    int'(bus.bomb_DR),    e_bomb);
        check_val("blast_DR",   int'(bus.blast_DR),   e_blastdr);
        check_val("draw_slot",  int'(bus.draw_slot),  e_slot);
    endtask

    task automatic clear_pulses();
        bus.OneSecPulse = 1'b0; bus.clear_all = 1'b0;
        bus.capacity_up = 1'b0; bus.radius_up = 1'b0;
    endtask

    task automatic do_reset();
        clear_pulses();
        bus.drop_bomb_key = 1'b0;
        resetN = 1'b0;
        #3;
        model_reset();
        @(posedge clk);
        #1;
        resetN = 1'b1;
    endtask

    task automatic press(input int x, input int y);
        bus.player_topLeftX = 11'(x); bus.player_topLeftY = 11'(y);
        bus.drop_bomb_key = 1'b1; tick();
        bus.drop_bomb_key = 1'b0; tick();
    endtask

    task automatic sec_pulse();
        bus.OneSecPulse = 1'b1; tick();
        bus.OneSecPulse = 1'b0;
    endtask

    initial begin
        bus.pixelX = 11'd0; bus.pixelY = 11'd0;
        bus.player_topLeftX = 11'd0; bus.player_topLeftY = 11'd0;
        do_reset();
        check_val("rst_left",   int'(bus.bombs_left), 2);
        check_val("rst_radius", int'(bus.radius),     1);
        check_val("rst_expl",   int'(bus.explosion),  0);
        check_val("rst_bombdr", int'(bus.bomb_DR),    0);

        // Held key at tile (3,2): one drop only; re-press on same tile rejected
        bus.player_topLeftX = 11'd96; bus.player_topLeftY = 11'd64;
        bus.drop_bomb_key = 1'b1;
        repeat (100) tick();
        check_val("held_key_left", int'(bus.bombs_left), 1);
        press(96, 64);
        check_val("dup_left", int'(bus.bombs_left), 1);
        repeat (2) begin sec_pulse(); repeat (3) tick(); end
        sec_pulse();
        check_val("fuse_blast", int'(bus.blast), 1);
        tick();
        check_val("blast_once", int'(bus.blast), 0);
        sec_pulse();
        check_val("ret_left", int'(bus.bombs_left), 2);

        // Draw: bomb at tile (4,2), pixel (130,70); then blast edge at tile 6
        bus.pixelX = 11'd130; bus.pixelY = 11'd70;
        press(128, 64);
        check_val("draw_bomb", int'(bus.bomb_DR),   1);
        check_val("draw_slot0", int'(bus.draw_slot), 0);
        repeat (3) sec_pulse();
        bus.pixelX = 11'd200; tick();
        check_val("edge_blastdr", int'(bus.blast_DR), 0);
        bus.pixelX = 11'd170; tick();
        check_val("near_blastdr", int'(bus.blast_DR), 1);
        sec_pulse();

        // Capacity: two drops empty the pool, third rejected, capacity_up saturates
        press(32, 32); press(64, 32);
        check_val("cap_empty", int'(bus.bombs_left), 0);
        press(160, 32);
        check_val("cap_reject", int'(bus.bombs_left), 0);
        bus.capacity_up = 1'b1; tick(); bus.capacity_up = 1'b0;
        check_val("cap_up", int'(bus.bombs_left), 1);
        repeat (4) begin bus.capacity_up = 1'b1; tick(); bus.capacity_up = 1'b0; tick(); end
        check_val("cap_sat", int'(bus.bombs_left), 1);

        // clear_all mid-fuse, then chain with radius 2
        bus.clear_all = 1'b1; tick(); bus.clear_all = 1'b0;
        check_val("clear_left", int'(bus.bombs_left), 3);
        bus.radius_up = 1'b1; tick(); bus.radius_up = 1'b0;
        press(128, 128); sec_pulse(); press(192, 128);
        sec_pulse(); sec_pulse();
        tick();
        check_val("chain_blast", int'(bus.blast), 1);
        sec_pulse();

        // Radius 1 repeat: B waits for its own fuse
        do_reset();
        press(128, 128); sec_pulse(); press(192, 128);
        sec_pulse(); sec_pulse();
        tick();
        check_val("nochain_blast", int'(bus.blast), 0);
        repeat (3) sec_pulse();

        // Random traffic
        for (int k = 0; k < 4000; k++) begin
            bus.OneSecPulse = ($urandom_range(0, 5) == 0);
            bus.capacity_up = ($urandom_range(0, 199) == 0);
            bus.radius_up   = ($urandom_range(0, 99) == 0);
            bus.clear_all   = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 3) == 0) bus.drop_bomb_key = ~bus.drop_bomb_key;
            if ($urandom_range(0, 7) == 0) begin
                bus.player_topLeftX = 11'($urandom_range(0, 8) * 32 + $urandom_range(0, 31));
                bus.player_topLeftY = 11'($urandom_range(0, 4) * 32 + $urandom_range(0, 31));
            end
            bus.pixelX = 11'($urandom_range(0, 319));
            bus.pixelY = 11'($urandom_range(0, 191));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
